// File: rtl/ofdm_frame_ctrl.sv
// Frame controller beside ofdm_sync: header check, symbol-count divider, abort/holdoff sequencing.
// Define OFDM_FRAME_CTRL_STATS_EN to build the saturating ok/err frame counters.
module ofdm_frame_ctrl #(
   parameter int HDR_TIMEOUT = 1024,
   parameter int HOLDOFF     = 16,
   parameter int MAX_LENGTH  = 4095
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sof,
   input  logic        eof,
   input  logic [16:0] hdr_tdata,
   input  logic        hdr_tvalid,
   output logic        hdr_tready,
   output logic [15:0] num_symbols,
   output logic        num_symbols_valid,
   output logic        frame_abort,
   output logic        busy,
   output logic [15:0] stat_frames_ok,
   output logic [15:0] stat_frames_err
);

   localparam int TIMER_W = $clog2(HDR_TIMEOUT + 1);
   localparam int HOLD_W  = $clog2(HOLDOFF + 1);
   localparam logic [31:0] RATE_CODES = {4'b0011, 4'b0001, 4'b1011, 4'b1001,
                                         4'b0111, 4'b0101, 4'b1111, 4'b1101};
   localparam logic [63:0] NDBPS_VALS = {8'd216, 8'd192, 8'd144, 8'd96,
                                         8'd72,  8'd48,  8'd36,  8'd24};

   typedef enum logic [2:0] {S_IDLE, S_WAIT_HDR, S_DIV, S_RUN, S_HOLDOFF} state_t;

   state_t               state_reg;
   logic [TIMER_W-1:0]   timer_reg;
   logic [HOLD_W-1:0]    hold_reg;
   logic                 sof_latched_reg;
   logic [4:0]           div_cnt_reg;
   logic [15:0]          dividend_reg;
   logic [7:0]           divisor_reg;
   logic [15:0]          quo_reg;
   logic [15:0]          rem_reg;

   logic [3:0]  hdr_rate;
   logic [11:0] hdr_len;
   logic        hdr_parity;
   logic [7:0]  rate_hit;
   logic [7:0]  ndbps_sel;
   logic        hdr_ok;
   logic        hs;
   logic        timeout_hit;
   logic [15:0] rem_shift;
   logic [15:0] rem_sub;
   logic        rem_ge;

   assign hdr_rate   = hdr_tdata[3:0];
   assign hdr_len    = hdr_tdata[15:4];
   assign hdr_parity = hdr_tdata[16];
   assign hs         = hdr_tvalid && hdr_tready;
   assign timeout_hit = (timer_reg == TIMER_W'(HDR_TIMEOUT - 1));

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_rate
         assign rate_hit[gi] = (hdr_rate == RATE_CODES[gi*4 +: 4]);
      end
   endgenerate

   always_comb begin
      ndbps_sel = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (rate_hit[i]) ndbps_sel = NDBPS_VALS[i*8 +: 8];
      end
   end

   assign hdr_ok = hdr_parity && (|rate_hit) && (hdr_len != 12'd0) &&
                   ({20'd0, hdr_len} <= 32'(MAX_LENGTH));

   // Restoring step: remainder stays below the 8-bit divisor, so bit 15 never carries out.
   assign rem_shift = {rem_reg[14:0], quo_reg[15]};
   assign rem_ge    = (rem_shift >= {8'd0, divisor_reg});
   assign rem_sub   = rem_shift - {8'd0, divisor_reg};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg         <= S_IDLE;
         timer_reg         <= '0;
         hold_reg          <= '0;
         sof_latched_reg   <= 1'b0;
         div_cnt_reg       <= '0;
         dividend_reg      <= '0;
         divisor_reg       <= '0;
         quo_reg           <= '0;
         rem_reg           <= '0;
         hdr_tready        <= 1'b0;
         busy              <= 1'b0;
         num_symbols       <= '0;
         num_symbols_valid <= 1'b0;
         frame_abort       <= 1'b0;
      end else begin
         num_symbols_valid <= 1'b0;
         frame_abort       <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               hdr_tready <= 1'b1;
               if (sof) begin
                  state_reg <= S_WAIT_HDR;
                  timer_reg <= '0;
                  busy      <= 1'b1;
               end
            end
            S_WAIT_HDR: begin
               if (hs && hdr_ok) begin
                  state_reg    <= S_DIV;
                  div_cnt_reg  <= '0;
                  dividend_reg <= 16'd22 + {1'b0, hdr_len, 3'b000};
                  divisor_reg  <= ndbps_sel;
                  hdr_tready   <= 1'b0;
               end else if (hs || (!sof && timeout_hit)) begin
                  state_reg       <= S_HOLDOFF;
                  hold_reg        <= '0;
                  sof_latched_reg <= 1'b0;
                  frame_abort     <= 1'b1;
                  busy            <= 1'b0;
               end else if (sof) begin
                  timer_reg <= '0;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            S_DIV: begin
               div_cnt_reg <= div_cnt_reg + 1'b1;
               if (div_cnt_reg == 5'd0) begin
                  quo_reg <= dividend_reg;
                  rem_reg <= '0;
               end else if (div_cnt_reg == 5'd17) begin
                  num_symbols       <= quo_reg + {15'd0, |rem_reg};
                  num_symbols_valid <= 1'b1;
                  state_reg         <= S_RUN;
               end else if (rem_ge) begin
                  rem_reg <= rem_sub;
                  quo_reg <= {quo_reg[14:0], 1'b1};
               end else begin
                  rem_reg <= rem_shift;
                  quo_reg <= {quo_reg[14:0], 1'b0};
               end
            end
            S_RUN: begin
               if (eof && sof) begin
                  state_reg  <= S_WAIT_HDR;
                  timer_reg  <= '0;
                  hdr_tready <= 1'b1;
               end else if (eof) begin
                  state_reg       <= S_HOLDOFF;
                  hold_reg        <= '0;
                  sof_latched_reg <= 1'b0;
                  hdr_tready      <= 1'b1;
                  busy            <= 1'b0;
               end else if (sof) begin
                  state_reg   <= S_WAIT_HDR;
                  timer_reg   <= '0;
                  frame_abort <= 1'b1;
                  hdr_tready  <= 1'b1;
               end
            end
            S_HOLDOFF: begin
               if (sof) sof_latched_reg <= 1'b1;
               if (hold_reg == HOLD_W'(HOLDOFF - 1)) begin
                  if (sof_latched_reg || sof) begin
                     state_reg <= S_WAIT_HDR;
                     timer_reg <= '0;
                     busy      <= 1'b1;
                  end else begin
                     state_reg <= S_IDLE;
                  end
               end else begin
                  hold_reg <= hold_reg + 1'b1;
               end
            end
            default: begin
               state_reg  <= S_IDLE;
               hdr_tready <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

`ifdef OFDM_FRAME_CTRL_STATS_EN
   logic        ok_evt;
   logic        err_evt;
   logic [15:0] ok_cnt_reg;
   logic [15:0] err_cnt_reg;

   assign ok_evt  = (state_reg == S_RUN) && eof;
   assign err_evt = ((state_reg == S_WAIT_HDR) && (hs ? !hdr_ok : (!sof && timeout_hit))) ||
                    ((state_reg == S_RUN) && sof && !eof);

   always_ff @(posedge clk) begin
      if (reset) begin
         ok_cnt_reg  <= '0;
         err_cnt_reg <= '0;
      end else begin
         if (ok_evt && (ok_cnt_reg != 16'hFFFF))   ok_cnt_reg  <= ok_cnt_reg + 1'b1;
         if (err_evt && (err_cnt_reg != 16'hFFFF)) err_cnt_reg <= err_cnt_reg + 1'b1;
      end
   end

   assign stat_frames_ok  = ok_cnt_reg;
   assign stat_frames_err = err_cnt_reg;
`else
   assign stat_frames_ok  = 16'd0;
   assign stat_frames_err = 16'd0;
`endif

endmodule

// File: tb/tb_ofdm_frame_ctrl.sv
// Self-checking bench for ofdm_frame_ctrl: header vector table plus hand-timed corner sequences.
`timescale 1ns/1ps
module tb_ofdm_frame_ctrl;

`ifdef OFDM_FRAME_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        sof;
   logic        eof;
   logic [16:0] hdr_tdata;
   logic        hdr_tvalid;
   logic        hdr_tready;
   logic [15:0] num_symbols;
   logic        num_symbols_valid;
   logic        frame_abort;
   logic        busy;
   logic [15:0] stat_frames_ok;
   logic [15:0] stat_frames_err;

   ofdm_frame_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .sof               (sof),
      .eof               (eof),
      .hdr_tdata         (hdr_tdata),
      .hdr_tvalid        (hdr_tvalid),
      .hdr_tready        (hdr_tready),
      .num_symbols       (num_symbols),
      .num_symbols_valid (num_symbols_valid),
      .frame_abort       (frame_abort),
      .busy              (busy),
      .stat_frames_ok    (stat_frames_ok),
      .stat_frames_err   (stat_frames_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int n_abort = 0;
   int exp_ok = 0;
   int exp_err = 0;
   logic [15:0] last_num = 16'd0;

   typedef struct {
      logic [15:0] num;
      int          acc;
   } sb_t;
   sb_t sb[$];
   sb_t mon_e;

   typedef struct {
      logic [3:0]  rate;
      logic [11:0] len;
      logic        par;
      logic        ok;
      logic [15:0] num;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (frame_abort) n_abort++;
      if (num_symbols_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: num_symbols=%0d with no header pending", num_symbols);
         end else begin
            mon_e = sb.pop_front();
            chk("num_symbols", int'(num_symbols), int'(mon_e.num));
            chk("strobe_latency", cyc - mon_e.acc, 18);
            $display("strobe: num_symbols=%0d latency=%0d", num_symbols, cyc - mon_e.acc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_sof();
      sof = 1'b1;
      step();
      sof = 1'b0;
   endtask

   task automatic pulse_eof();
      eof = 1'b1;
      step();
      eof = 1'b0;
   endtask

   task automatic send_hdr(input logic [3:0] rate, input logic [11:0] len, input logic par,
                           input logic ok, input logic [15:0] num);
      sb_t e;
      hdr_tdata  = {par, len, rate};
      hdr_tvalid = 1'b1;
      step();
      hdr_tvalid = 1'b0;
      if (ok) begin
         e.num = num;
         e.acc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic wait_strobe(input string nm);
      int k = 0;
      while (num_symbols_valid !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      chk({nm, "_strobe_seen"}, int'(num_symbols_valid), 1);
   endtask

   task automatic chk_stats(input string nm);
      chk({nm, "_stat_ok"},  int'(stat_frames_ok),  STATS ? exp_ok  : 0);
      chk({nm, "_stat_err"}, int'(stat_frames_err), STATS ? exp_err : 0);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int a0;
      a0 = n_abort;
      pulse_sof();
      chk("sof_busy", int'(busy), 1);
      send_hdr(v.rate, v.len, v.par, v.ok, v.num);
      if (v.ok) begin
         chk("div_tready", int'(hdr_tready), 0);
         wait_strobe("vec");
         step();
         chk("run_busy", int'(busy), 1);
         pulse_eof();
         exp_ok++;
         chk("eof_busy", int'(busy), 0);
         chk("vec_no_abort", n_abort - a0, 0);
         last_num = v.num;
      end else begin
         chk("bad_hdr_abort", int'(frame_abort), 1);
         exp_err++;
         step();
         chk("bad_hdr_abort_width", int'(frame_abort), 0);
         chk("num_held", int'(num_symbols), int'(last_num));
      end
      repeat (20) step();
      chk_stats("vec");
      $display("vec %0d: rate=%b len=%0d par=%0b -> num_symbols=%0d aborts=%0d",
               idx, v.rate, v.len, v.par, num_symbols, n_abort - a0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{4'b0000, 12'd100,  1'b1, 1'b0, 16'd0};
      tbl[1] = '{4'b1101, 12'd0,    1'b1, 1'b0, 16'd0};
      tbl[2] = '{4'b1101, 12'd100,  1'b0, 1'b0, 16'd0};
      tbl[3] = '{4'b1101, 12'd100,  1'b1, 1'b1, 16'd35};
      tbl[4] = '{4'b0011, 12'd4095, 1'b1, 1'b1, 16'd152};
      tbl[5] = '{4'b1011, 12'd1,    1'b1, 1'b1, 16'd1};
      tbl[6] = '{4'b0101, 12'd50,   1'b1, 1'b1, 16'd9};
      tbl[7] = '{4'b1001, 12'd1000, 1'b1, 1'b1, 16'd84};
      tbl[8] = '{4'b0001, 12'd2000, 1'b1, 1'b1, 16'd84};
      tbl[9] = '{4'b0111, 12'd9,    1'b1, 1'b1, 16'd2};

      reset = 1'b1; sof = 1'b0; eof = 1'b0; hdr_tvalid = 1'b0; hdr_tdata = '0;
      repeat (3) step();
      chk("rst_tready", int'(hdr_tready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_num", int'(num_symbols), 0);
      chk("rst_valid", int'(num_symbols_valid), 0);
      chk("rst_abort", int'(frame_abort), 0);
      chk_stats("rst");
      reset = 1'b0;
      step();
      chk("idle_tready", int'(hdr_tready), 1);
      chk("idle_busy", int'(busy), 0);

      for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

      // Truncated frame: sof while running
      pulse_sof();
      send_hdr(4'b1101, 12'd100, 1'b1, 1'b1, 16'd35);
      wait_strobe("trunc");
      pulse_sof();
      exp_err++;
      chk("trunc_abort", int'(frame_abort), 1);
      chk("trunc_busy", int'(busy), 1);
      chk("trunc_tready", int'(hdr_tready), 1);
      step();
      chk("trunc_abort_width", int'(frame_abort), 0);
      $display("seq: sof during RUN -> abort, back in WAIT_HDR");

      // eof and sof together: count ok, no abort, straight to WAIT_HDR
      send_hdr(4'b0101, 12'd50, 1'b1, 1'b1, 16'd9);
      wait_strobe("eofsof");
      sof = 1'b1; eof = 1'b1;
      step();
      sof = 1'b0; eof = 1'b0;
      exp_ok++;
      chk("eofsof_busy", int'(busy), 1);
      chk("eofsof_tready", int'(hdr_tready), 1);
      chk("eofsof_no_abort", int'(frame_abort), 0);
      $display("seq: eof+sof together -> ok, WAIT_HDR");

      // sof latched during HOLDOFF re-enters WAIT_HDR exactly 16 cycles after eof
      send_hdr(4'b1111, 12'd10, 1'b1, 1'b1, 16'd3);
      wait_strobe("holdoff");
      pulse_eof();
      exp_ok++;
      chk("holdoff_enter_busy", int'(busy), 0);
      repeat (4) step();
      pulse_sof();
      repeat (10) step();
      chk("holdoff_still_idle", int'(busy), 0);
      step();
      chk("holdoff_exit_busy", int'(busy), 1);
      $display("seq: sof during HOLDOFF -> WAIT_HDR after 16 cycles");

      // Header timeout: abort exactly HDR_TIMEOUT edges after entering WAIT_HDR
      repeat (1023) step();
      chk("pre_timeout_abort", int'(frame_abort), 0);
      step();
      chk("timeout_abort", int'(frame_abort), 1);
      exp_err++;
      step();
      chk("timeout_abort_width", int'(frame_abort), 0);
      chk("timeout_busy", int'(busy), 0);
      repeat (20) step();
      chk_stats("timeout");
      $display("seq: header timeout -> abort");

      // Header handshake on the timeout edge wins over the timeout
      pulse_sof();
      repeat (1023) step();
      send_hdr(4'b1101, 12'd100, 1'b1, 1'b1, 16'd35);
      chk("edge_hdr_no_abort", int'(frame_abort), 0);
      chk("edge_hdr_busy", int'(busy), 1);
      chk("edge_hdr_tready", int'(hdr_tready), 0);
      wait_strobe("edge_hdr");
      pulse_eof();
      exp_ok++;
      repeat (20) step();
      chk_stats("edge_hdr");
      $display("seq: header on timeout cycle -> accepted");

      // Reset while dividing: no strobe, everything back to reset values
      pulse_sof();
      send_hdr(4'b1101, 12'd100, 1'b1, 1'b1, 16'd35);
      repeat (5) step();
      reset = 1'b1;
      sb.delete();
      exp_ok = 0;
      exp_err = 0;
      step();
      chk("divrst_tready", int'(hdr_tready), 0);
      chk("divrst_busy", int'(busy), 0);
      chk("divrst_num", int'(num_symbols), 0);
      chk("divrst_valid", int'(num_symbols_valid), 0);
      chk("divrst_abort", int'(frame_abort), 0);
      chk_stats("divrst");
      reset = 1'b0;
      repeat (30) step();
      chk("divrst_num_after", int'(num_symbols), 0);
      chk("divrst_idle_busy", int'(busy), 0);
      $display("seq: reset during DIV -> no strobe");

      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ofdm_frame_ctrl.md
# ofdm_frame_ctrl

Frame-level controller for the OFDM synchronizer datapath. Watches the synchronizer's `sof`/`eof` pulses, accepts the decoded SIGNAL header from the downstream header decoder, computes the frame's data-symbol count with an iterative divider, and drives the synchronizer's `num_symbols`/`num_symbols_valid` inputs. Invalid headers, header timeouts and truncated frames raise an abort pulse that flushes the synchronizer. It sits beside `ofdm_sync` inside the RFNoC OFDM block, in the `ce_clk` domain.

## Interface
- `HDR_TIMEOUT`, 1024: cycles allowed from `sof` to header acceptance.
- `HOLDOFF`, 16: dead cycles after frame end or abort; minimum 1.
- `MAX_LENGTH`, 4095: largest legal LENGTH field, in bytes.

- `clk`  in  1  clock (`ce_clk`).
- `reset`  in  1  synchronous, active-high.
- `sof`  in  1  start-of-frame pulse from the synchronizer.
- `eof`  in  1  end-of-frame pulse from the synchronizer.
- `hdr_tdata`  in  17  header word: [3:0] RATE {R1,R2,R3,R4}, [15:4] LENGTH, [16] parity_ok.
- `hdr_tvalid`  in  1  header valid.
- `hdr_tready`  out  1  header ready.
- `num_symbols`  out  16  data symbols in the frame; held until the next update.
- `num_symbols_valid`  out  1  one-cycle strobe for `num_symbols`.
- `frame_abort`  out  1  one-cycle pulse that flushes the synchronizer.
- `busy`  out  1  high in WAIT_HDR, DIV and RUN.
- `stat_frames_ok`  out  16  count of completed frames.
- `stat_frames_err`  out  16  count of aborted frames.

## Operation
- NDBPS lookup on RATE: 1101→24, 1111→36, 0101→48, 0111→72, 1001→96, 1011→144, 0001→192, 0011→216. Any other code is invalid.
- `num_symbols` = ceil((16 + 8·LENGTH + 6) / NDBPS).
  - The 16-bit dividend is 22 + 8·LENGTH.
  - A 16-iteration restoring shift-subtract divider produces the quotient. Add 1 if the remainder is nonzero.
  - The result is zero-extended to 16 bits.
- A header is valid only when parity_ok = 1, RATE is in the table, and 1 ≤ LENGTH ≤ `MAX_LENGTH`.
- States: IDLE, WAIT_HDR, DIV, RUN, HOLDOFF.
  - IDLE: `hdr_tready` = 1; accepted headers are discarded. `sof` → WAIT_HDR and clears the timer.
  - WAIT_HDR: `hdr_tready` = 1; the timer increments every cycle.
    - Valid header accepted → DIV.
    - Invalid header accepted → `frame_abort`, err++, → HOLDOFF.
    - Timer = `HDR_TIMEOUT`−1 → `frame_abort`, err++, → HOLDOFF.
    - `sof` restarts the timer and stays in WAIT_HDR.
    - A header handshake in the same cycle as the timeout wins.
  - DIV: `hdr_tready` = 0. Load for 1 cycle, then iterate for 16 cycles. Then pulse `num_symbols_valid` and go to RUN. `sof` and `eof` are ignored.
  - RUN: `hdr_tready` = 0.
    - `eof` → ok++, → HOLDOFF.
    - `sof` (truncated frame) → `frame_abort`, err++, → WAIT_HDR with the timer cleared.
    - If `eof` and `sof` arrive together, `eof` is processed first (ok++), then the state goes to WAIT_HDR with the timer cleared and no abort.
  - HOLDOFF: `hdr_tready` = 1; headers are discarded.
    - A `sof` seen here is latched.
    - After `HOLDOFF` cycles: go to WAIT_HDR if a `sof` was latched, otherwise to IDLE.
- `eof` outside RUN is ignored.
- Statistics counters saturate at 16'hFFFF.

## Timing
- Reset values: state IDLE; `num_symbols` 0; `num_symbols_valid` 0; `frame_abort` 0; `busy` 0; stats 0; `hdr_tready` 0 while `reset` is high.
- All outputs are registered. There is no combinational path from any input to any output.
- `num_symbols_valid` asserts exactly 18 cycles after the header-accept edge, and `num_symbols` is updated in that same cycle.
- `frame_abort` asserts in the cycle after the triggering event, for exactly 1 cycle.
- The `busy` transition happens on the same edge as the state change.
- Asserting `reset` mid-frame returns the block to IDLE on the next edge:
  - the divider result is discarded;
  - no strobe or abort is emitted;
  - stats are cleared.
- Minimum `sof`-to-`num_symbols_valid` latency is 19 cycles, with the header presented in the cycle after `sof`.

## Configuration
- `OFDM_FRAME_CTRL_STATS_EN` defined: the two saturating counters are built and driven as described above.
- Not defined: the counters are removed, `stat_frames_ok` and `stat_frames_err` are tied to 0, and all other behaviour is identical.

## Test plan
- `sof`, then header RATE = 1101, LENGTH = 100, parity_ok = 1 → `num_symbols` = 35 with a strobe 18 cycles after accept. `eof` → ok = 1, then IDLE after 16 cycles.
- Header RATE = 0011, LENGTH = 4095 → `num_symbols` = 152. Header RATE = 1011, LENGTH = 1 → `num_symbols` = 1.
- `sof` with no header for 1024 cycles → `frame_abort` pulse, err = 1, no `num_symbols_valid`. Header arriving exactly on the timeout cycle → accepted, no abort.
- Headers with RATE = 0000, with LENGTH = 0, or with parity_ok = 0 → abort each time, err = 3, `num_symbols` stays 0.
- `sof` during RUN → abort, err++, back in WAIT_HDR. `sof` during HOLDOFF → WAIT_HDR after 16 cycles. `reset` in DIV → no strobe, all outputs at reset values.
- Without `OFDM_FRAME_CTRL_STATS_EN`: repeat scenario 1 → stats stay 0 and `num_symbols` = 35.
